// File: rtl/encoder_emulator.sv
// Synthetic quadrature encoder source.
// Emits exactly Rate_Lat rising edges of A per window of WINDOW OUT_CLK ticks.
// The quadrature steps are spread evenly through the window by a phase accumulator.
// The window timing lines up with the pulse-counting encoder front end, so this
// block can drive that counter in loopback or stand in for a missing motor.
module encoder_emulator #(
    parameter int WINDOW = 240,
    parameter int RW     = 8
) (
    input  logic          OUT_CLK,
    input  logic          RST,
    input  logic          Enable,
    input  logic          Dir,
    input  logic [RW-1:0] Rate,
    output logic          A,
    output logic          B,
    output logic          Win,
    output logic [RW-1:0] Rate_Lat,
    output logic          Sat
);

    // The fastest legal rate is one quadrature step per tick, and one A cycle
    // takes four steps. So a window can hold at most WINDOW/4 A rising edges.
    localparam int              WCW     = $clog2(WINDOW);
    localparam int              MAXR    = WINDOW / 4;
    localparam logic [WCW-1:0]  WC_LAST = WCW'(WINDOW - 1);
    localparam logic [WCW-1:0]  WC_PRE  = WCW'(WINDOW - 2);
    localparam logic [15:0]     WIN16   = 16'(WINDOW);
    localparam logic [15:0]     MAXR16  = 16'(MAXR);

    // The phase states are named by their {A,B} levels. Adjacent states differ
    // in one bit only, so A and B never change on the same tick.
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_10 = 2'b10,
        PH_11 = 2'b11,
        PH_01 = 2'b01
    } phase_t;

    logic [WCW-1:0] wc;
    logic [15:0]    acc;
    logic [15:0]    inc;
    logic [15:0]    sum;
    logic           boundary;
    logic           step;
    logic           en_lat;
    logic           dir_lat;
    logic           rate_over;
    phase_t         phase;

    // Forward steps trace 00->10->11->01. Reverse steps trace the same loop
    // backwards. Either way, each lap of four steps holds one A rising edge.
    function automatic phase_t next_phase(input phase_t cur, input logic fwd);
        phase_t nxt;
        nxt = cur;
        case (cur)
            PH_00:   nxt = fwd ? PH_10 : PH_01;
            PH_10:   nxt = fwd ? PH_11 : PH_00;
            PH_11:   nxt = fwd ? PH_01 : PH_10;
            PH_01:   nxt = fwd ? PH_00 : PH_11;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

    // Each tick adds 4*Rate_Lat to the accumulator. A step fires whenever the
    // sum crosses WINDOW. Across a whole window this gives exactly 4*Rate_Lat
    // steps and leaves the accumulator back at zero.
    always_comb begin
        boundary  = (wc == WC_LAST);
        inc       = en_lat ? (16'(Rate_Lat) << 2) : 16'd0;
        sum       = acc + inc;
        step      = (sum >= WIN16);
        rate_over = (16'(Rate) > MAXR16);
    end

    // The window counter runs freely whatever Enable does. Win is set one tick
    // early so that it is high during the last tick of the window.
    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            wc  <= '0;
            Win <= 1'b0;
        end else begin
            wc  <= boundary ? '0 : wc + 1'b1;
            Win <= (wc == WC_PRE);
        end
    end

    // Commands are sampled only on the boundary tick. A mid-window change to
    // Enable, Dir or Rate therefore waits for the next window.
    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            Rate_Lat <= '0;
            Sat      <= 1'b0;
            en_lat   <= 1'b0;
            dir_lat  <= 1'b1;
        end else if (boundary) begin
            Rate_Lat <= rate_over ? RW'(MAXR) : Rate;
            Sat      <= rate_over;
            en_lat   <= Enable;
            dir_lat  <= Dir;
        end
    end

    // Accumulator and phase state machine. The boundary tick still steps with
    // the old rate before clearing acc. Phase is kept across windows and is
    // only forced back to 00 by reset.
    always_ff @(posedge OUT_CLK or posedge RST) begin
        if (RST) begin
            acc   <= '0;
            phase <= PH_00;
        end else begin
            if (step) begin
                phase <= next_phase(phase, dir_lat);
            end
            if (boundary) begin
                acc <= '0;
            end else if (step) begin
                acc <= sum - WIN16;
            end else begin
                acc <= sum;
            end
        end
    end

    assign A = phase[1];
    assign B = phase[0];

endmodule

// File: tb/tb_encoder_emulator.sv
// Directed bench for encoder_emulator with WINDOW=240 and RW=8.
// Each window is stepped tick by tick. A/B activity and Win timing are
// tallied and compared against values worked out by hand.
module tb_encoder_emulator;

    logic       OUT_CLK;
    logic       RST;
    logic       Enable;
    logic       Dir;
    logic [7:0] Rate;
    logic       A;
    logic       B;
    logic       Win;
    logic [7:0] Rate_Lat;
    logic       Sat;

    int checks;
    int errors;

    int         a_rise;
    int         a_chg;
    int         b_chg;
    int         both_chg;
    int         first_a;
    int         first_b;
    int         win_cnt;
    int         win_pos;
    logic [7:0] lat_at_last;

    encoder_emulator #(
        .WINDOW (240),
        .RW     (8)
    ) dut (
        .OUT_CLK  (OUT_CLK),
        .RST      (RST),
        .Enable   (Enable),
        .Dir      (Dir),
        .Rate     (Rate),
        .A        (A),
        .B        (B),
        .Win      (Win),
        .Rate_Lat (Rate_Lat),
        .Sat      (Sat)
    );

    // Free-running 100 MHz clock.
    initial begin
        OUT_CLK = 1'b0;
        forever #5 OUT_CLK = ~OUT_CLK;
    end

    // Advance one rising edge, then settle 1 ns so that sampling stays clear of the edge.
    task automatic tick();
        @(posedge OUT_CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic en, input logic d);
        Rate   = r;
        Enable = en;
        Dir    = d;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Start at wc=0 and run 240 ticks, ending at wc=0 of the next window.
    // Every step that belongs to this window, including the one from the
    // boundary edge, appears inside the run.
    task automatic run_window(input int chg_tick, input logic [7:0] chg_rate,
                              input logic chg_en, input logic chg_dir);
        logic pa;
        logic pb;
        a_rise = 0; a_chg = 0; b_chg = 0; both_chg = 0;
        first_a = -1; first_b = -1; win_cnt = 0; win_pos = -1;
        lat_at_last = 8'hxx;
        for (int i = 1; i <= 240; i++) begin
            pa = A;
            pb = B;
            tick();
            if (A !== pa) a_chg++;
            if (B !== pb) b_chg++;
            if (A !== pa && B !== pb) both_chg++;
            if (pa == 1'b0 && A == 1'b1) begin
                a_rise++;
                if (first_a < 0) first_a = i;
            end
            if (pb == 1'b0 && B == 1'b1 && first_b < 0) first_b = i;
            if (Win === 1'b1) begin
                win_cnt++;
                win_pos = i;
            end
            if (i == 239) lat_at_last = Rate_Lat;
            if (i == chg_tick) applyStimulus(chg_rate, chg_en, chg_dir);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        applyStimulus(8'd5, 1'b1, 1'b1);
        repeat (3) tick();

        checkOutput("rst_A", int'(A), 0);
        checkOutput("rst_B", int'(B), 0);
        checkOutput("rst_Win", int'(Win), 0);
        checkOutput("rst_RateLat", int'(Rate_Lat), 0);
        checkOutput("rst_Sat", int'(Sat), 0);

        RST = 1'b0;

        // Window 1 runs at the reset rate of 0, so A and B stay static.
        run_window(-1, 8'd5, 1'b1, 1'b1);
        checkOutput("w1_a_chg", a_chg, 0);
        checkOutput("w1_b_chg", b_chg, 0);
        checkOutput("w1_win_cnt", win_cnt, 1);
        checkOutput("w1_win_pos", win_pos, 239);
        checkOutput("w1_lat_last", int'(lat_at_last), 0);
        checkOutput("w1_lat_after", int'(Rate_Lat), 5);
        checkOutput("w1_sat_after", int'(Sat), 0);

        // Window 2 runs at rate 5 forward: one step every 12 ticks, A leads B.
        // Rate moves to 20 at wc=100, which must not affect this window.
        run_window(100, 8'd20, 1'b1, 1'b1);
        checkOutput("w2_a_rise", a_rise, 5);
        checkOutput("w2_a_chg", a_chg, 10);
        checkOutput("w2_b_chg", b_chg, 10);
        checkOutput("w2_first_a", first_a, 12);
        checkOutput("w2_first_b", first_b, 24);
        checkOutput("w2_win_pos", win_pos, 239);
        checkOutput("w2_lat_last", int'(lat_at_last), 5);
        checkOutput("w2_lat_after", int'(Rate_Lat), 20);

        // Window 3 runs at rate 20: acc climbs 80, 160, 240, so a step fires every 3 ticks.
        run_window(50, 8'd100, 1'b1, 1'b1);
        checkOutput("w3_a_rise", a_rise, 20);
        checkOutput("w3_first_a", first_a, 3);
        checkOutput("w3_lat_after", int'(Rate_Lat), 60);
        checkOutput("w3_sat_after", int'(Sat), 1);

        // Window 4 has Rate 100 saturated to 60, so there is a step every tick.
        run_window(10, 8'd5, 1'b1, 1'b0);
        checkOutput("w4_a_rise", a_rise, 60);
        checkOutput("w4_a_chg", a_chg, 120);
        checkOutput("w4_b_chg", b_chg, 120);
        checkOutput("w4_both_chg", both_chg, 0);
        checkOutput("w4_win_cnt", win_cnt, 1);
        checkOutput("w4_sat_after", int'(Sat), 0);

        // Window 5 runs at rate 5 in reverse: B rises at step 1, A rises at step 2.
        run_window(100, 8'd5, 1'b0, 1'b1);
        checkOutput("w5_a_rise", a_rise, 5);
        checkOutput("w5_first_b", first_b, 12);
        checkOutput("w5_first_a", first_a, 24);
        checkOutput("w5_both_chg", both_chg, 0);

        // Window 6 has Enable latched low, so A and B hold their levels.
        run_window(100, 8'd0, 1'b1, 1'b1);
        checkOutput("w6_a_chg", a_chg, 0);
        checkOutput("w6_b_chg", b_chg, 0);
        checkOutput("w6_A_level", int'(A), 0);
        checkOutput("w6_B_level", int'(B), 0);
        checkOutput("w6_lat_after", int'(Rate_Lat), 0);

        // Window 7 runs at rate 0: no edges, but Win still pulses on time.
        run_window(50, 8'd5, 1'b1, 1'b1);
        checkOutput("w7_a_chg", a_chg, 0);
        checkOutput("w7_b_chg", b_chg, 0);
        checkOutput("w7_win_pos", win_pos, 239);
        checkOutput("w7_lat_after", int'(Rate_Lat), 5);

        // Window 8 runs at rate 5 forward and is cut short at wc=130. By then
        // 10 steps have fired, leaving the phase at 11.
        repeat (130) tick();
        checkOutput("w8_pre_A", int'(A), 1);
        checkOutput("w8_pre_B", int'(B), 1);
        checkOutput("w8_pre_lat", int'(Rate_Lat), 5);
        #2;
        RST = 1'b1;
        applyStimulus(8'd7, 1'b1, 1'b1);
        #1;
        checkOutput("rst2_A", int'(A), 0);
        checkOutput("rst2_B", int'(B), 0);
        checkOutput("rst2_Win", int'(Win), 0);
        checkOutput("rst2_RateLat", int'(Rate_Lat), 0);
        checkOutput("rst2_Sat", int'(Sat), 0);
        repeat (2) tick();
        RST = 1'b0;

        // After the reset is released, the first window is static and Win
        // arrives at 239 ticks after the release.
        run_window(-1, 8'd7, 1'b1, 1'b1);
        checkOutput("w9_a_chg", a_chg, 0);
        checkOutput("w9_win_cnt", win_cnt, 1);
        checkOutput("w9_win_pos", win_pos, 239);
        checkOutput("w9_lat_after", int'(Rate_Lat), 7);

        // Window 10 runs at rate 7: inc=28, so the first step fires on tick 9.
        // A downstream counter would see 7 A rises here.
        run_window(-1, 8'd7, 1'b1, 1'b1);
        checkOutput("w10_a_rise", a_rise, 7);
        checkOutput("w10_first_a", first_a, 9);
        checkOutput("w10_both_chg", both_chg, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
